fetch_queue: RTL and testbench

//  Two-wide instruction fetch queue between the instruction ROM (fetch) and decode/rename.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the two-wide instruction fetch queue.
package fetch_pkg;

    localparam int FQ_ADDR_W = 32;
    localparam int FQ_DATA_W = 32;
    localparam int FQ_DEPTH  = 8;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0] addr;
        logic [FQ_DATA_W-1:0] instr;
        logic                 pred_taken;
        logic [FQ_ADDR_W-1:0] pred_target;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-wide fetch queue: up to two instructions in and two out per cycle,
// with flush on redirect and backpressure to the PC stage.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = FQ_ADDR_W,
    parameter int DATA_WIDTH = FQ_DATA_W,
    parameter int DEPTH      = FQ_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [1:0]                  in_valid,
    input  logic [ADDR_WIDTH-1:0]       in_addr_0,
    input  logic [ADDR_WIDTH-1:0]       in_addr_1,
    input  logic [DATA_WIDTH-1:0]       in_instr_0,
    input  logic [DATA_WIDTH-1:0]       in_instr_1,
    input  logic                        in_pred_taken_0,
    input  logic [ADDR_WIDTH-1:0]       in_pred_target_0,
    output logic                        in_ready,
    output logic [1:0]                  out_valid,
    output logic [ADDR_WIDTH-1:0]       out_addr_0,
    output logic [ADDR_WIDTH-1:0]       out_addr_1,
    output logic [DATA_WIDTH-1:0]       out_instr_0,
    output logic [DATA_WIDTH-1:0]       out_instr_1,
    output logic                        out_pred_taken_0,
    output logic                        out_pred_taken_1,
    output logic [ADDR_WIDTH-1:0]       out_pred_target_0,
    output logic [ADDR_WIDTH-1:0]       out_pred_target_1,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_enq;
    logic            w_deq;
    logic [1:0]      w_enq_n;
    logic [1:0]      w_deq_n;
    logic [1:0]      w_out_valid;
    logic [PW-1:0]   w_head_1;
    logic [PW-1:0]   w_tail_1;
    fq_entry_t       w_slot0;
    fq_entry_t       w_slot1;
    fq_entry_t       w_rd0;
    fq_entry_t       w_rd1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic [1:0] n);
        return p + PW'(n);
    endfunction

    // Readiness looks only at registered occupancy; a same-cycle dequeue is not credited.
    assign in_ready    = (r_count <= CW'(DEPTH - 2));
    assign w_out_valid = {(r_count >= CW'(2)), (r_count >= CW'(1))};

    assign w_enq   = in_ready && !flush;
    assign w_deq   = out_ready && !flush;
    assign w_enq_n = w_enq ? {in_valid[1] & in_valid[0], in_valid[1] ^ in_valid[0]} : 2'd0;
    assign w_deq_n = w_deq ? {w_out_valid[1], w_out_valid[0] & ~w_out_valid[1]} : 2'd0;

    assign w_head_1 = ptr_inc(r_head, 2'd1);
    assign w_tail_1 = ptr_inc(r_tail, 2'd1);

    assign w_slot0 = '{addr: in_addr_0, instr: in_instr_0,
                       pred_taken: in_pred_taken_0, pred_target: in_pred_target_0};
    assign w_slot1 = '{addr: in_addr_1, instr: in_instr_1,
                       pred_taken: 1'b0, pred_target: '0};

    // Entry RAM carries no reset; validity comes solely from the pointers.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            if (in_valid[0]) begin
                r_mem[r_tail] <= w_slot0;
                if (in_valid[1]) r_mem[w_tail_1] <= w_slot1;
            end else if (in_valid[1]) begin
                r_mem[r_tail] <= w_slot1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= ptr_inc(r_tail, w_enq_n);
            r_head  <= ptr_inc(r_head, w_deq_n);
            r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
        end
    end

    assign w_rd0 = w_out_valid[0] ? r_mem[r_head]   : '0;
    assign w_rd1 = w_out_valid[1] ? r_mem[w_head_1] : '0;

    assign out_valid         = w_out_valid;
    assign out_addr_0        = w_rd0.addr;
    assign out_instr_0       = w_rd0.instr;
    assign out_pred_taken_0  = w_rd0.pred_taken;
    assign out_pred_target_0 = w_rd0.pred_target;
    assign out_addr_1        = w_rd1.addr;
    assign out_instr_1       = w_rd1.instr;
    assign out_pred_taken_1  = w_rd1.pred_taken;
    assign out_pred_target_1 = w_rd1.pred_target;
    assign count             = r_count;

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        int'(r_count) <= DEPTH);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !w_enq || (int'(r_count) + int'(w_enq_n) <= DEPTH));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [1:0]    in_valid;
    logic [AW-1:0] in_addr_0, in_addr_1;
    logic [DW-1:0] in_instr_0, in_instr_1;
    logic          in_pred_taken_0;
    logic [AW-1:0] in_pred_target_0;
    logic          in_ready;
    logic [1:0]    out_valid;
    logic [AW-1:0] out_addr_0, out_addr_1;
    logic [DW-1:0] out_instr_0, out_instr_1;
    logic          out_pred_taken_0, out_pred_taken_1;
    logic [AW-1:0] out_pred_target_0, out_pred_target_1;
    logic          out_ready;
    logic [CW-1:0] count;

    fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_addr_0(in_addr_0), .in_addr_1(in_addr_1),
        .in_instr_0(in_instr_0), .in_instr_1(in_instr_1),
        .in_pred_taken_0(in_pred_taken_0), .in_pred_target_0(in_pred_target_0),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_addr_0(out_addr_0), .out_addr_1(out_addr_1),
        .out_instr_0(out_instr_0), .out_instr_1(out_instr_1),
        .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
        .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] instr;
        logic          tk;
        logic [AW-1:0] tgt;
    } ment_t;

    ment_t mq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("in_ready",  64'(in_ready),  64'((D - n) >= 2));
        chk("count",     64'(count),     64'(n));
        chk("out_valid", 64'(out_valid), 64'({n >= 2, n >= 1}));
        chk("addr0",  64'(out_addr_0),        n >= 1 ? 64'(mq[0].addr)  : 64'(0));
        chk("instr0", 64'(out_instr_0),       n >= 1 ? 64'(mq[0].instr) : 64'(0));
        chk("tk0",    64'(out_pred_taken_0),  n >= 1 ? 64'(mq[0].tk)    : 64'(0));
        chk("tgt0",   64'(out_pred_target_0), n >= 1 ? 64'(mq[0].tgt)   : 64'(0));
        chk("addr1",  64'(out_addr_1),        n >= 2 ? 64'(mq[1].addr)  : 64'(0));
        chk("instr1", 64'(out_instr_1),       n >= 2 ? 64'(mq[1].instr) : 64'(0));
        chk("tk1",    64'(out_pred_taken_1),  n >= 2 ? 64'(mq[1].tk)    : 64'(0));
        chk("tgt1",   64'(out_pred_target_1), n >= 2 ? 64'(mq[1].tgt)   : 64'(0));
    endtask

    // Checks current outputs, advances the reference by one cycle, then clocks the DUT.
    task automatic step();
        ment_t nq[$];
        bit rdy;
        int k;
        check_all();
        rdy = (D - mq.size()) >= 2;
        nq = mq;
        if (flush) begin
            nq.delete();
        end else begin
            if (out_ready) begin
                k = (nq.size() >= 2) ? 2 : nq.size();
                repeat (k) void'(nq.pop_front());
            end
            if (rdy) begin
                if (in_valid[0]) nq.push_back('{in_addr_0, in_instr_0, in_pred_taken_0, in_pred_target_0});
                if (in_valid[1]) nq.push_back('{in_addr_1, in_instr_1, 1'b0, 32'h0});
            end
        end
        @(posedge clk);
        #1;
        mq = nq;
    endtask

    task automatic drive(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic tk, input logic [AW-1:0] tgt, input logic ordy, input logic fl);
        in_valid         = v;
        in_addr_0        = a0;
        in_addr_1        = a1;
        in_instr_0       = a0 ^ 32'hDEAD_0000;
        in_instr_1       = a1 ^ 32'hBEEF_0000;
        in_pred_taken_0  = tk;
        in_pred_target_0 = tgt;
        out_ready        = ordy;
        flush            = fl;
    endtask

    task automatic idle(input logic ordy);
        drive(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, ordy, 1'b0);
    endtask

    task automatic do_flush();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] pc;

        rst = 1'b1;
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        step();

        // Reset mid-fill at count = 3
        drive(2'b11, 32'h100, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(2'b01, 32'h108, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        idle(1'b0);
        chk("t1_pre_count", 64'(count), 64'(3));
        #2;
        rst = 1'b1;
        #1;
        chk("t1_rst_count",     64'(count),     64'(0));
        chk("t1_rst_out_valid", 64'(out_valid), 64'(0));
        chk("t1_rst_in_ready",  64'(in_ready),  64'(1));
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Two 2-wide groups, no dequeue
        drive(2'b11, 32'h00, 32'h04, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(2'b11, 32'h08, 32'h0C, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        idle(1'b0);
        chk("t2_count",     64'(count),      64'(4));
        chk("t2_addr0",     64'(out_addr_0), 64'(32'h00));
        chk("t2_addr1",     64'(out_addr_1), 64'(32'h04));
        chk("t2_out_valid", 64'(out_valid),  64'(2'b11));
        step();

        // Fill to 8, fifth group dropped
        do_flush();
        pc = 32'h200;
        for (int g = 0; g < 5; g++) begin
            drive(2'b11, pc, pc + 4, 1'b0, 32'h0, 1'b0, 1'b0);
            step();
            pc = pc + 8;
        end
        idle(1'b0);
        chk("t3_count8",    64'(count),    64'(8));
        chk("t3_in_ready8", 64'(in_ready), 64'(0));
        step();

        // Occupancy of 7 also blocks input
        do_flush();
        for (int g = 0; g < 3; g++) begin
            drive(2'b11, 32'h300 + 8 * g, 32'h304 + 8 * g, 1'b0, 32'h0, 1'b0, 1'b0);
            step();
        end
        drive(2'b01, 32'h318, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(2'b11, 32'h31C, 32'h320, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t3_in_ready7", 64'(in_ready), 64'(0));
        step();
        idle(1'b0);
        chk("t3_count7", 64'(count), 64'(7));
        step();

        // count = 1, dequeue and 2-wide enqueue together
        do_flush();
        drive(2'b01, 32'h400, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        drive(2'b11, 32'h404, 32'h408, 1'b0, 32'h0, 1'b1, 1'b0);
        step();
        idle(1'b0);
        chk("t4_count", 64'(count),      64'(2));
        chk("t4_head",  64'(out_addr_0), 64'(32'h404));
        step();

        // Slot-1-only group compacts to the tail
        do_flush();
        drive(2'b10, 32'h99, 32'h14, 1'b1, 32'h77, 1'b0, 1'b0);
        step();
        idle(1'b0);
        chk("t5_out_valid", 64'(out_valid),        64'(2'b01));
        chk("t5_addr0",     64'(out_addr_0),       64'(32'h14));
        chk("t5_tk0",       64'(out_pred_taken_0), 64'(0));
        step();

        // Stored prediction, then flush beats a simultaneous enqueue
        do_flush();
        drive(2'b01, 32'h30, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
        step();
        idle(1'b0);
        chk("t6_tk0",  64'(out_pred_taken_0),  64'(1));
        chk("t6_tgt0", 64'(out_pred_target_0), 64'(32'h40));
        drive(2'b11, 32'h34, 32'h38, 1'b1, 32'h40, 1'b1, 1'b1);
        step();
        idle(1'b0);
        chk("t6_count",     64'(count),     64'(0));
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        step();

        // Wrap: 20 groups streamed straight through
        do_flush();
        exp_pc = 32'h1000;
        for (int g = 0; g < 23; g++) begin
            if (g < 20) drive(2'b11, 32'h1000 + 8 * g, 32'h1004 + 8 * g, 1'b0, 32'h0, 1'b1, 1'b0);
            else        idle(1'b1);
            if (out_valid[0]) begin
                chk("wrap_pc0", 64'(out_addr_0), 64'(exp_pc));
                exp_pc = exp_pc + 4;
            end
            if (out_valid[1]) begin
                chk("wrap_pc1", 64'(out_addr_1), 64'(exp_pc));
                exp_pc = exp_pc + 4;
            end
            step();
        end
        chk("wrap_all_seen", 64'(exp_pc), 64'(32'h1000 + 160));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0));
            step();
        end
        idle(1'b0);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
